sd_wb_reg_slave: RTL

SD_WB_REG_SLAVE -- requirements
Module: sd_wb_reg_slave

---
 rtl/sd_wb_pkg.sv | 57 +++++
 rtl/sd_wb_reg_slave.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sd_wb_pkg.sv
// Shared Wishbone definitions for the SD controller register slave.
// Holds the bus data width default, register map, CTI codes, FSM state and
// termination encodings, plus the per-beat termination decode.
package sd_wb_pkg;

  localparam int unsigned WB_DATA_W = 32;

  // Register map (word index on ADR_I[6:4]).
  typedef enum logic [2:0] {
    REG_OP     = 3'd0,
    REG_STATUS = 3'd1,
    REG_ARG    = 3'd2,
    REG_RESP   = 3'd3,
    REG_RDDATA = 3'd4,
    REG_WRDATA = 3'd5,
    REG_UNMAP6 = 3'd6,
    REG_UNMAP7 = 3'd7
  } reg_addr_e;

  // Wishbone cycle type identifier codes.
  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_CONST   = 3'b001,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } aCTI;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    TERM_ACK = 2'd0,
    TERM_ERR = 2'd1,
    TERM_RTY = 2'd2
  } term_e;

  // How a beat terminates, given direction, register and FIFO flags.
  function automatic term_e decode_term(input logic      we,
                                        input reg_addr_e adr,
                                        input logic      rd_empty,
                                        input logic      wr_full);
    term_e t;
    t = TERM_ERR;
    case (adr)
      REG_OP, REG_ARG:       t = TERM_ACK;
      REG_STATUS, REG_RESP:  t = we ? TERM_ERR : TERM_ACK;
      REG_RDDATA:            t = we ? TERM_ERR : (rd_empty ? TERM_RTY : TERM_ACK);
      REG_WRDATA:            t = we ? (wr_full ? TERM_RTY : TERM_ACK) : TERM_ERR;
      default:               t = TERM_ERR;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sd_wb_reg_slave.sv
// Wishbone register slave for the SD controller.
// Exposes op/arg command registers, status/response read-back and the
// read/write data FIFO windows. Every beat terminates one cycle after it is
// accepted with exactly one of ACK_O/ERR_O/RTY_O.
// Optional feature: define SD_WB_BURST_EN to accept CTI 001/010 bursts
// (one beat per cycle); otherwise every access is classic (2 cycles each).
// Ports:
//   CLK_I, RST_I (sync, active high)          clock / reset
//   CYC_I STB_I WE_I ADR_I SEL_I DAT_I CTI_I BTE_I   Wishbone slave inputs
//   DAT_O ACK_O ERR_O RTY_O                   Wishbone slave outputs
//   op_o arg_o op_strobe_o                    command registers / pulse
//   status_i resp_i                           read-only sources
//   rd_data_i rd_empty_i rd_pop_o             read FIFO head / pop
//   wr_data_o wr_full_i wr_push_o             write FIFO data / push
module sd_wb_reg_slave
  import sd_wb_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              CYC_I,
  input  logic              STB_I,
  input  logic              WE_I,
  input  logic [6:4]        ADR_I,
  input  logic              SEL_I,
  input  logic [DATA_W-1:0] DAT_I,
  input  logic [2:0]        CTI_I,
  input  logic [1:0]        BTE_I,
  output logic [DATA_W-1:0] DAT_O,
  output logic              ACK_O,
  output logic              ERR_O,
  output logic              RTY_O,
  output logic [DATA_W-1:0] op_o,
  output logic [DATA_W-1:0] arg_o,
  output logic              op_strobe_o,
  input  logic [DATA_W-1:0] status_i,
  input  logic [DATA_W-1:0] resp_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              rd_empty_i,
  output logic              rd_pop_o,
  output logic [DATA_W-1:0] wr_data_o,
  input  logic              wr_full_i,
  output logic              wr_push_o
);

  state_e            state_q, state_d;
  reg_addr_e         adr_q, adr_d;
  logic              ack_q, ack_d, err_q, err_d, rty_q, rty_d;
  logic              op_stb_q, op_stb_d, pop_q, pop_d, push_q, push_d;
  logic [DATA_W-1:0] op_q, op_d, arg_q, arg_d, wr_data_q, wr_data_d;

  logic      req_c, beat_c, burst_cont_c;
  reg_addr_e adr_c;
  term_e     term_c;

  // BTE is ignored; CTI is only consumed by the burst build.
  logic unused_inputs;
  assign unused_inputs = ^{BTE_I, CTI_I};

  assign req_c  = CYC_I & STB_I;
  assign adr_c  = reg_addr_e'(ADR_I);
  assign term_c = decode_term(WE_I, adr_c, rd_empty_i, wr_full_i);
  // A beat is accepted whenever no termination for a final beat is showing.
  assign beat_c = req_c & ((state_q == ST_IDLE) | (state_q == ST_BURST));

`ifdef SD_WB_BURST_EN
  assign burst_cont_c = (CTI_I == 3'(CTI_CONST)) | (CTI_I == 3'(CTI_INCR));
`else
  assign burst_cont_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK_I) begin
    if (RST_I) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: only an ACKed, non-final burst beat keeps the burst open.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_BURST: begin
        if (req_c) state_d = (burst_cont_c && term_c == TERM_ACK) ? ST_BURST : ST_ACK;
        else       state_d = ST_IDLE;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/next-register logic: side effects only on ACKed beats.
  always_comb begin
    adr_d     = adr_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rty_d     = 1'b0;
    op_stb_d  = 1'b0;
    pop_d     = 1'b0;
    push_d    = 1'b0;
    op_d      = op_q;
    arg_d     = arg_q;
    wr_data_d = wr_data_q;
    if (beat_c) begin
      adr_d = adr_c;
      ack_d = (term_c == TERM_ACK);
      err_d = (term_c == TERM_ERR);
      rty_d = (term_c == TERM_RTY);
      if (term_c == TERM_ACK) begin
        if (WE_I && SEL_I) begin
          case (adr_c)
            REG_OP: begin
              op_d     = DAT_I;
              op_stb_d = 1'b1;
            end
            REG_ARG: arg_d = DAT_I;
            REG_WRDATA: begin
              wr_data_d = DAT_I;
              push_d    = 1'b1;
            end
            default: ;
          endcase
        end
        if (!WE_I && adr_c == REG_RDDATA) pop_d = 1'b1;
      end
    end
  end

  // Registered outputs and command registers.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      adr_q     <= REG_OP;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rty_q     <= 1'b0;
      op_stb_q  <= 1'b0;
      pop_q     <= 1'b0;
      push_q    <= 1'b0;
      op_q      <= '0;
      arg_q     <= '0;
      wr_data_q <= '0;
    end else begin
      adr_q     <= adr_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rty_q     <= rty_d;
      op_stb_q  <= op_stb_d;
      pop_q     <= pop_d;
      push_q    <= push_d;
      op_q      <= op_d;
      arg_q     <= arg_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign ACK_O     = ack_q;
  assign ERR_O     = err_q;
  assign RTY_O     = rty_q;
  assign op_o      = op_q;
  assign arg_o     = arg_q;
  assign wr_data_o = wr_data_q;

  // A reset arriving during the termination cycle aborts the beat, so the
  // side-effect pulses are suppressed for that cycle.
  assign op_strobe_o = op_stb_q & ~RST_I;
  assign rd_pop_o    = pop_q & ~RST_I;
  assign wr_push_o   = push_q & ~RST_I;

  // Read data is only driven while an ACK is showing.
  always_comb begin
    DAT_O = '0;
    if (ack_q) begin
      case (adr_q)
        REG_OP:     DAT_O = op_q;
        REG_STATUS: DAT_O = status_i;
        REG_ARG:    DAT_O = arg_q;
        REG_RESP:   DAT_O = resp_i;
        REG_RDDATA: DAT_O = rd_data_i;
        default:    DAT_O = '0;
      endcase
    end
  end

endmodule
